// File: rtl/interpol_seq.sv
`default_nettype none
// ============================================================================
// Module      : interpol_seq
// Description : Sequences signed X samples from a small input FIFO through an
//               external handshaked interpolator and presents each Y result
//               on a valid/ready output port, one transaction at a time.
//               Optional watchdog: define INTERPOL_SEQ_TIMEOUT_EN to abort a
//               transaction stuck waiting on the interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
module interpol_seq #(
  parameter int N              = 16,
  parameter int M              = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_data,
  output logic                   ip_start,
  output logic [N-1:0]           ip_x,
  input  logic                   ip_ready,
  input  logic [M-1:0]           ip_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M-1:0]           out_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_LW = $clog2(DEPTH) + 1;
  localparam logic [c_LW-1:0] c_FULL    = c_LW'(DEPTH);
  localparam logic [c_AW-1:0] c_PTR_MAX = c_AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAITLO = 3'd2,
    S_WAITHI = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_timeout;
  logic            w_wd_hit;

  // in_ready is forced low while reset is held so nothing is accepted into a FIFO being cleared
  assign in_ready = reset && (r_level != c_FULL);
  assign w_push   = in_valid && in_ready;
  assign level    = r_level;
  assign busy     = reset && ((r_state != S_IDLE) || (r_level != '0));

  // Sample storage; contents need no reset because level/pointers gate every read
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_MAX) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef INTERPOL_SEQ_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_WD_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  logic [c_CW-1:0] r_wd_cnt;
  logic            r_err;

  // Hit on the last permitted wait cycle so the abort lands exactly TIMEOUT_CYCLES cycles in
  assign w_wd_hit = ((r_state == S_WAITLO) || (r_state == S_WAITHI)) && (r_wd_cnt == c_WD_LAST);
  assign err      = r_err;

  // Watchdog counts wait-state cycles per transaction; err is sticky until reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_next == S_START) begin
        r_wd_cnt <= '0;
      end else if ((r_state == S_WAITLO) || (r_state == S_WAITHI)) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_wd_hit = 1'b0;
  assign err      = 1'b0;
`endif

  // Next-state decode; a genuine interpolator response takes priority over the watchdog
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_level != '0) && ip_ready) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        w_next = S_WAITLO;
      end
      S_WAITLO: begin
        if (!ip_ready) begin
          w_next = S_WAITHI;
        end else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAITHI: begin
        if (ip_ready) begin
          w_capture = 1'b1;
          w_next    = S_OUT;
        end else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, operand, start pulse and result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      ip_start  <= 1'b0;
      ip_x      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      r_state  <= w_next;
      ip_start <= (w_next == S_START);
      if (w_pop) begin
        ip_x <= r_mem[r_rd_ptr];
      end
      if (w_capture) begin
        out_data  <= ip_y;
        out_valid <= 1'b1;
      end else if ((r_state == S_OUT) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
